// File: rtl/gpr_pkg.sv
// gpr_pkg: shared defaults and the next-register-value function used by
// both the write path and the read bypass of gpr_multi.
package gpr_pkg;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_FLAG_REG = 30;
    localparam int DEF_FLAG_BIT = 0;
    localparam int MAX_W        = 64;

    // wr1 first, then wr0 (caller already gated it with !ofw), then the flag bit
    function automatic logic [MAX_W-1:0] gpr_next(
        input logic [MAX_W-1:0] old_v,
        input logic             w1,
        input logic [MAX_W-1:0] d1,
        input logic             w0,
        input logic [MAX_W-1:0] d0,
        input logic             flag,
        input logic [5:0]       fbit
    );
        logic [MAX_W-1:0] v;
        v = w1 ? d1 : old_v;
        v = w0 ? d0 : v;
        if (flag) v[fbit] = 1'b1;
        return v;
    endfunction
endpackage

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard: per-register load busy bits with a registered population
// count; an issue wins over a same-cycle clear of the same register.
module gpr_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_set,
    input  logic [ADDR_W-1:0]   i_set_addr,
    input  logic                i_clr,
    input  logic [ADDR_W-1:0]   i_clr_addr,
    output logic [NUM_REGS-1:0] o_busy,
    output logic [ADDR_W:0]     o_cnt
);
    logic [NUM_REGS-1:0] r_busy;
    logic [ADDR_W:0]     r_cnt;
    logic [NUM_REGS-1:0] w_nxt;
    logic                w_set, w_clr, w_inc, w_dec;

    assign w_set = i_set && i_set_addr != '0;
    assign w_clr = i_clr && i_clr_addr != '0;
    assign w_inc = w_set && !r_busy[i_set_addr];
    assign w_dec = w_clr && r_busy[i_clr_addr] && !(w_set && i_set_addr == i_clr_addr);

    always_comb begin
        w_nxt = r_busy;
        if (w_clr) w_nxt[i_clr_addr] = 1'b0;
        if (w_set) w_nxt[i_set_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_nxt;
            r_cnt  <= r_cnt + (ADDR_W+1)'(w_inc) - (ADDR_W+1)'(w_dec);
        end
    end

    assign o_busy = r_busy;
    assign o_cnt  = r_cnt;
endmodule

// File: rtl/gpr_multi.sv
// gpr_multi: multi-port register file with two write ports, overflow flag
// merge, load scoreboard and optional write-to-read bypass.
module gpr_multi import gpr_pkg::*; #(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = 2,
    parameter int FLAG_REG = DEF_FLAG_REG,
    parameter int FLAG_BIT = DEF_FLAG_BIT,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     of_write_en,
    input  logic                     overflow,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic [ADDR_W:0]          busy_cnt,
    output logic                     stall
);
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [DATA_W-1:0]   w_next [NUM_REGS];
    logic [NUM_REGS-1:0] w_busy;
    logic                w_ofw;

    assign w_ofw = of_write_en & overflow;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        if (g == 0) begin : g_zero
            assign w_next[g] = '0;
        end else begin : g_wr
            logic w_hit1, w_hit0;
            assign w_hit1    = wr1_en && wr1_addr == ADDR_W'(g);
            assign w_hit0    = wr0_en && !w_ofw && wr0_addr == ADDR_W'(g);
            assign w_next[g] = DATA_W'(gpr_next(MAX_W'(r_regs[g]), w_hit1, MAX_W'(wr1_data),
                                                w_hit0, MAX_W'(wr0_data),
                                                w_ofw && g == FLAG_REG, 6'(FLAG_BIT)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_regs <= '{default: '0};
        else     r_regs <= w_next;
    end

    gpr_scoreboard #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_set      (issue_en),
        .i_set_addr (issue_addr),
        .i_clr      (wr1_en),
        .i_clr_addr (wr1_addr),
        .o_busy     (w_busy),
        .o_cnt      (busy_cnt)
    );

    // a load completing this cycle unblocks its reader unless it is re-issued
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] w_a;
        assign w_a = rd_addr[p*ADDR_W +: ADDR_W];
        assign rd_data[p*DATA_W +: DATA_W] = BYPASS != 0 ? w_next[w_a] : r_regs[w_a];
        assign rd_busy[p] = w_busy[w_a] && !(BYPASS != 0 && wr1_en && wr1_addr == w_a
                                             && !(issue_en && issue_addr == w_a));
    end

    assign stall = |rd_busy;
endmodule

// File: tb/tb_gpr_multi.sv
// tb_gpr_multi: table-driven vectors with hand-written expectations queued
// at drive time and compared mid-cycle against a bypass and a non-bypass DUT.
module tb_gpr_multi;
    localparam int AW = 5, DW = 32, NR = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data, rd_data_nb;
    logic [NR-1:0]    rd_busy, rd_busy_nb;
    logic             wr0_en, of_write_en, overflow, wr1_en, issue_en;
    logic [AW-1:0]    wr0_addr, wr1_addr, issue_addr;
    logic [DW-1:0]    wr0_data, wr1_data;
    logic [AW:0]      busy_cnt, busy_cnt_nb;
    logic             stall, stall_nb;

    always #5 clk = ~clk;

    gpr_multi #(.BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .of_write_en(of_write_en), .overflow(overflow),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .busy_cnt(busy_cnt), .stall(stall)
    );

    gpr_multi #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .of_write_en(of_write_en), .overflow(overflow),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .busy_cnt(busy_cnt_nb), .stall(stall_nb)
    );

    typedef struct {
        logic rs, w0e; logic [4:0] w0a; logic [31:0] w0d;
        logic ofe, ov, w1e; logic [4:0] w1a; logic [31:0] w1d;
        logic ie; logic [4:0] ia, ra0, ra1;
        logic chk; logic [31:0] e0, e1, enb; logic [1:0] eb; logic [5:0] ec;
    } vec_t;

    typedef struct {
        logic [31:0] e0, e1, enb; logic [1:0] eb; logic [5:0] ec;
    } exp_t;

    vec_t vt[$];
    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t v(
        input logic rs, input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
        input logic ofe, input logic ov,
        input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
        input logic ie, input logic [4:0] ia, input logic [4:0] ra0, input logic [4:0] ra1,
        input logic chk, input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] enb,
        input logic [1:0] eb, input logic [5:0] ec);
        vec_t r;
        r.rs = rs; r.w0e = w0e; r.w0a = w0a; r.w0d = w0d; r.ofe = ofe; r.ov = ov;
        r.w1e = w1e; r.w1a = w1a; r.w1d = w1d; r.ie = ie; r.ia = ia; r.ra0 = ra0; r.ra1 = ra1;
        r.chk = chk; r.e0 = e0; r.e1 = e1; r.enb = enb; r.eb = eb; r.ec = ec;
        return r;
    endfunction

    task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", n, act, exp_v, $time);
        end
    endtask

    task automatic apply(input vec_t x);
        exp_t e;
        @(posedge clk);
        #1;
        rst = x.rs; wr0_en = x.w0e; wr0_addr = x.w0a; wr0_data = x.w0d;
        of_write_en = x.ofe; overflow = x.ov;
        wr1_en = x.w1e; wr1_addr = x.w1a; wr1_data = x.w1d;
        issue_en = x.ie; issue_addr = x.ia; rd_addr = {x.ra1, x.ra0};
        if (x.chk) begin
            e.e0 = x.e0; e.e1 = x.e1; e.enb = x.enb; e.eb = x.eb; e.ec = x.ec;
            q.push_back(e);
        end
        #5;
        if (x.chk) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL queue empty at %0t", $time);
            end else begin
                e = q.pop_front();
                cmp("rd0", rd_data[31:0], e.e0);
                cmp("rd1", rd_data[63:32], e.e1);
                cmp("rd0_nobypass", rd_data_nb[31:0], e.enb);
                cmp("rd_busy", 32'(rd_busy), 32'(e.eb));
                cmp("busy_cnt", 32'(busy_cnt), 32'(e.ec));
                cmp("busy_cnt_nobypass", 32'(busy_cnt_nb), 32'(e.ec));
                cmp("stall", 32'(stall), 32'(|e.eb));
            end
        end
    endtask

    initial begin
        rst = 1'b1; wr0_en = 0; wr0_addr = 0; wr0_data = 0; of_write_en = 0; overflow = 0;
        wr1_en = 0; wr1_addr = 0; wr1_data = 0; issue_en = 0; issue_addr = 0; rd_addr = 0;
        //          rs w0e w0a w0d       ofe ov w1e w1a w1d     ie ia ra0 ra1 chk e0        e1        enb       eb     ec
        vt.push_back(v(1, 0, 0, 0,         0, 0, 0, 0, 0,       0, 0, 0,  0,  0, 0,        0,        0,        2'b00, 0));
        vt.push_back(v(0, 1, 5, 'h1234,    0, 0, 0, 0, 0,       0, 0, 5,  0,  1, 'h1234,   0,        0,        2'b00, 0));
        vt.push_back(v(0, 1, 0, 'hFFFF,    0, 0, 0, 0, 0,       0, 0, 0,  5,  1, 0,        'h1234,   0,        2'b00, 0));
        vt.push_back(v(0, 1, 30, 'hF0F0,   0, 0, 0, 0, 0,       0, 0, 30, 7,  1, 'hF0F0,   0,        0,        2'b00, 0));
        vt.push_back(v(0, 1, 7, 'hAAAA,    1, 1, 0, 0, 0,       0, 0, 30, 7,  1, 'hF0F1,   0,        'hF0F0,   2'b00, 0));
        vt.push_back(v(0, 0, 0, 0,         0, 0, 0, 0, 0,       0, 0, 30, 7,  1, 'hF0F1,   0,        'hF0F1,   2'b00, 0));
        vt.push_back(v(0, 1, 7, 'hAAAA,    1, 0, 0, 0, 0,       0, 0, 7,  30, 1, 'hAAAA,   'hF0F1,   0,        2'b00, 0));
        vt.push_back(v(0, 1, 9, 'h22,      0, 0, 1, 9, 'h11,    0, 0, 9,  7,  1, 'h22,     'hAAAA,   0,        2'b00, 0));
        vt.push_back(v(0, 0, 0, 0,         0, 0, 0, 0, 0,       1, 4, 9,  4,  1, 'h22,     0,        'h22,     2'b00, 0));
        vt.push_back(v(0, 0, 0, 0,         0, 0, 0, 0, 0,       0, 0, 4,  9,  1, 0,        'h22,     0,        2'b01, 1));
        vt.push_back(v(0, 0, 0, 0,         0, 0, 1, 4, 'h55,    0, 0, 4,  0,  1, 'h55,     0,        0,        2'b00, 1));
        vt.push_back(v(0, 0, 0, 0,         0, 0, 0, 0, 0,       0, 0, 4,  4,  1, 'h55,     'h55,     'h55,     2'b00, 0));
        vt.push_back(v(0, 0, 0, 0,         0, 0, 0, 0, 0,       1, 4, 0,  4,  1, 0,        'h55,     0,        2'b00, 0));
        vt.push_back(v(0, 0, 0, 0,         0, 0, 1, 4, 'h66,    1, 4, 4,  0,  1, 'h66,     0,        'h55,     2'b01, 1));
        vt.push_back(v(0, 0, 0, 0,         0, 0, 0, 0, 0,       0, 0, 4,  0,  1, 'h66,     0,        'h66,     2'b01, 1));
        vt.push_back(v(0, 0, 0, 0,         0, 0, 0, 0, 0,       1, 0, 0,  4,  1, 0,        'h66,     0,        2'b10, 1));
        vt.push_back(v(0, 0, 0, 0,         0, 0, 0, 0, 0,       1, 2, 0,  0,  1, 0,        0,        0,        2'b00, 1));
        vt.push_back(v(0, 0, 0, 0,         0, 0, 0, 0, 0,       1, 3, 2,  0,  1, 0,        0,        0,        2'b01, 2));
        vt.push_back(v(0, 0, 0, 0,         0, 0, 0, 0, 0,       1, 6, 3,  2,  1, 0,        0,        0,        2'b11, 3));
        vt.push_back(v(1, 1, 5, 'h99,      0, 0, 0, 0, 0,       1, 7, 0,  0,  0, 0,        0,        0,        2'b00, 0));
        vt.push_back(v(0, 0, 0, 0,         0, 0, 0, 0, 0,       0, 0, 5,  6,  1, 0,        0,        0,        2'b00, 0));
        vt.push_back(v(0, 0, 0, 0,         0, 0, 0, 0, 0,       0, 0, 30, 4,  1, 0,        0,        0,        2'b00, 0));
        vt.push_back(v(0, 1, 7, 'h1,       1, 1, 1, 30, 'h8,    0, 0, 30, 7,  1, 'h9,      0,        0,        2'b00, 0));
        vt.push_back(v(0, 0, 0, 0,         0, 0, 1, 0, 'h77,    0, 0, 0,  30, 1, 0,        'h9,      0,        2'b00, 0));
        vt.push_back(v(0, 0, 0, 0,         0, 0, 0, 0, 0,       0, 0, 30, 0,  1, 'h9,      0,        'h9,      2'b00, 0));
        foreach (vt[i]) apply(vt[i]);
        // fill four busy bits one per cycle, then drain them with loads
        for (int k = 0; k < 4; k++)
            apply(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'(10 + k), 5'(10 + k), 10, 1,
                    0, 0, 0, {k > 0, 1'b0}, 6'(k)));
        for (int k = 0; k < 4; k++)
            apply(v(0, 0, 0, 0, 0, 0, 1, 5'(10 + k), 32'(256 + k), 0, 0, 5'(10 + k), 13, 1,
                    32'(256 + k), (k == 3) ? 32'h103 : 32'h0, 0, {k < 3, 1'b0}, 6'(4 - k)));
        apply(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13, 10, 1, 'h103, 'h100, 'h103, 2'b00, 0));
        if (q.size() != 0) begin
            total++; bad++;
            $display("FAIL leftover expectations got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gpr_multi.md
Name: gpr_multi

Overview:
Parametrised general-purpose register file for the MIPS core. It supports a configurable number of read ports, two write ports, and an overflow-flag write into a configurable flag register. It adds a per-register load scoreboard (busy bits with a population counter) and an optional write-to-read bypass. It sits between decode (reads, issue marking) and the ALU/memory writeback stages.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, number of architectural registers (power of two, >= 2)
ADDR_W, $clog2(NUM_REGS), register address width (derived)
NUM_RD, 2, number of read ports (1..4)
FLAG_REG, 30, index of the register holding the overflow flag (must be non-zero)
FLAG_BIT, 0, bit position of the overflow flag within FLAG_REG
BYPASS, 1, 1 means same-cycle writes are forwarded to reads; 0 means reads return stored state only

Ports:
clk  in  1  clock; all state updates on its rising edge
rst  in  1  synchronous, active-high reset
rd_addr  in  NUM_RD*ADDR_W  read addresses; port i is slice i
rd_data  out  NUM_RD*DATA_W  read data (combinational)
rd_busy  out  NUM_RD  scoreboard busy bit for each read address
wr0_en  in  1  ALU writeback enable
wr0_addr  in  ADDR_W  ALU writeback address
wr0_data  in  DATA_W  ALU writeback data
of_write_en  in  1  current ALU op is overflow-trapping
overflow  in  1  ALU overflow indication
wr1_en  in  1  memory/load writeback enable
wr1_addr  in  ADDR_W  load writeback address
wr1_data  in  DATA_W  load writeback data
issue_en  in  1  a load has been issued; mark its destination busy
issue_addr  in  ADDR_W  load destination register
busy_cnt  out  ADDR_W+1  number of registers currently marked busy
stall  out  1  high when any rd_busy bit is high

Behaviour:
- Reset (rst=1 at a clock edge) clears every register to 0, every busy bit to 0, and busy_cnt to 0. Reset dominates all other inputs in the same cycle. A reset asserted mid-operation discards pending busy marks.
- Register 0 always reads 0 and is never busy. Writes and issues to address 0 are ignored.
- ofw = of_write_en & overflow.
- Write order within one edge (later steps override earlier ones):
  - Step 1: the wr1 write.
  - Step 2: the wr0 write, only if !ofw.
  - Step 3: if ofw, set FLAG_REG[FLAG_BIT]=1. All other bits of FLAG_REG keep the value produced by steps 1-2.
- wr0 and wr1 to the same address in the same cycle: the wr0 data is stored.
- When ofw=1, the wr0 write is suppressed regardless of wr0_en.
- Scoreboard:
  - wr1 write to addr A clears busy[A].
  - issue_en to addr A sets busy[A].
  - Issue and clear of the same A in the same cycle: busy stays 1 (set wins).
  - A wr0 write does not touch busy bits.
- busy_cnt is registered and updates on the same edge as the busy bits: +1 for a 0->1 transition, -1 for a 1->0 transition. It cannot overflow because it is bounded by NUM_REGS-1.
- Reads are zero-latency combinational.
- With BYPASS=1, rd_data equals the value the register will hold after the current edge under the write-order rules above, including the flag merge.
- With BYPASS=0, rd_data returns the stored value only.
- rd_busy[i] = busy[rd_addr_i]. With BYPASS=1, it is forced low when a wr1 write to that address occurs in the same cycle and no issue to that address occurs in the same cycle.
- stall = OR of rd_busy.

Decomposition:
- Shared package gpr_pkg holds:
  - the default DATA_W and NUM_REGS
  - the FLAG_REG and FLAG_BIT constants
  - a function computing next-register value from (old value, wr0, wr1, ofw). Both the write logic and the bypass use this function, so they cannot diverge.
- One natural sub-module, gpr_scoreboard, owns the busy bits, busy_cnt and the set/clear priority. The top level holds the storage array, the write sequencing and the read muxes.

Test Plan:
- Reset, then wr0 $5=0x1234 -> next cycle rd_addr0=5 gives 0x1234. wr0 $0=0xFFFF -> rd $0 = 0.
- wr0 $7=0xAAAA with of_write_en=1, overflow=1 -> $7 unchanged, $30 bit0=1, other $30 bits unchanged. Without overflow, $7=0xAAAA.
- Same cycle: wr1 $9=0x11, wr0 $9=0x22 -> $9=0x22. With BYPASS=1, the same-cycle read of $9 returns 0x22; with BYPASS=0 it returns the old value.
- issue $4 -> busy_cnt=1, rd $4 gives rd_busy=1 and stall=1. wr1 $4=0x55 -> same-cycle rd_busy=0 (BYPASS=1), busy_cnt=0 next cycle.
- issue $4 and wr1 $4 in the same cycle while $4 is busy -> $4 stays busy and busy_cnt is unchanged.
- Mark $2, $3, $6 busy, then assert rst -> next cycle all regs 0, busy_cnt=0, stall=0.
